// File: rtl/pe_net_pkg.sv
// Shared flit layout for the PE network interface: field widths, field
// extraction helpers and the saturating counter step.
package pe_net_pkg;

   localparam int DATA_WIDTH  = 36;
   localparam int ADDR_WIDTH  = 4;
   localparam int PW          = DATA_WIDTH - ADDR_WIDTH;
   localparam int COUNT_WIDTH = 16;

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   function automatic logic [ADDR_WIDTH-1:0] flit_dest(input logic [DATA_WIDTH-1:0] flit);
      return flit[DATA_WIDTH-1 -: ADDR_WIDTH];
   endfunction

   function automatic logic [PW-1:0] flit_payload(input logic [DATA_WIDTH-1:0] flit);
      return flit[PW-1:0];
   endfunction

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value,
                                                      input logic                   enable);
      return (enable && (value != COUNT_MAX)) ? value + 1'b1 : value;
   endfunction

endpackage

// File: rtl/pe_net_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head reads as zero when empty
// and a full FIFO never accepts a push, even alongside a pop.
module pe_net_fifo #(
   parameter int Width = 32,
   parameter int Depth = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push_valid,
   input  logic [Width-1:0] i_push_data,
   input  logic             i_pop_ready,
   output logic [Width-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int IW   = $clog2(Depth);
   localparam int PTRW = IW + 1;

   logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [Width-1:0] mem_q [Depth];
   logic             push;
   logic             pop;

   // Same index with differing wrap bits means the writer has lapped the reader.
   always_comb begin
      o_full  = (wr_ptr_q[PTRW-1] != rd_ptr_q[PTRW-1]) &&
                (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
      o_empty = (wr_ptr_q == rd_ptr_q);
      o_head  = o_empty ? '0 : mem_q[rd_ptr_q[IW-1:0]];
      push    = i_push_valid && !o_full;
      pop     = i_pop_ready && !o_empty;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q[IW-1:0]] <= i_push_data;
      end
   end

endmodule

// File: rtl/pe_net_if.sv
// Network endpoint for one PE: packs PE sends into flits for the leaf switch,
// and unpacks flits addressed to this PE while dropping and counting the rest.
module pe_net_if
   import pe_net_pkg::*;
#(
   parameter int                   DataWidth = DATA_WIDTH,
   parameter int                   AddrWidth = ADDR_WIDTH,
   parameter logic [AddrWidth-1:0] MyAddr    = '0,
   parameter int                   TxDepth   = 4,
   parameter int                   RxDepth   = 4,
   localparam int                  PayloadWidth = DataWidth - AddrWidth
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [AddrWidth-1:0]    i_pe_dest,
   input  logic [PayloadWidth-1:0] i_pe_payload,
   input  logic                    i_pe_valid,
   output logic                    o_pe_ready,
   output logic [DataWidth-1:0]    o_data,
   output logic                    o_data_valid,
   input  logic                    i_data_ready,
   input  logic [DataWidth-1:0]    i_data,
   input  logic                    i_data_valid,
   output logic                    o_data_ready,
   output logic [PayloadWidth-1:0] o_pe_rx_payload,
   output logic                    o_pe_rx_valid,
   input  logic                    i_pe_rx_ready,
   output logic [15:0]             o_tx_count,
   output logic [15:0]             o_rx_count,
   output logic [15:0]             o_misroute_count
);

   logic                    alive_q, alive_d;
   logic [COUNT_WIDTH-1:0]  tx_count_q, tx_count_d;
   logic [COUNT_WIDTH-1:0]  rx_count_q, rx_count_d;
   logic [COUNT_WIDTH-1:0]  misroute_count_q, misroute_count_d;

   logic                    tx_full, tx_empty;
   logic                    rx_full, rx_empty;
   logic [DataWidth-1:0]    tx_head;
   logic [PayloadWidth-1:0] rx_head;
   logic [AddrWidth-1:0]    rx_dest;
   logic [PayloadWidth-1:0] rx_payload;

   logic                    tx_push, tx_fire;
   logic                    rx_accept, rx_push, rx_misroute, rx_fire;

   // The package helpers only fit the default flit layout; other sizes slice directly.
   if (DataWidth == DATA_WIDTH && AddrWidth == ADDR_WIDTH) begin : g_pkg_fields
      always_comb begin
         rx_dest    = flit_dest(i_data);
         rx_payload = flit_payload(i_data);
      end
   end else begin : g_param_fields
      always_comb begin
         rx_dest    = i_data[DataWidth-1 -: AddrWidth];
         rx_payload = i_data[PayloadWidth-1:0];
      end
   end

   always_comb begin
      o_pe_ready      = alive_q && !tx_full;
      tx_push         = i_pe_valid && o_pe_ready;
      o_data_valid    = !tx_empty;
      o_data          = tx_head;
      tx_fire         = o_data_valid && i_data_ready;

      // Misrouted flits are still accepted so a stray flit cannot stall the switch.
      o_data_ready    = alive_q && !rx_full;
      rx_accept       = i_data_valid && o_data_ready;
      rx_push         = rx_accept && (rx_dest == MyAddr);
      rx_misroute     = rx_accept && (rx_dest != MyAddr);
      o_pe_rx_valid   = !rx_empty;
      o_pe_rx_payload = rx_head;
      rx_fire         = o_pe_rx_valid && i_pe_rx_ready;
   end

   always_comb begin
      alive_d          = 1'b1;
      tx_count_d       = sat_inc(tx_count_q, tx_fire);
      rx_count_d       = sat_inc(rx_count_q, rx_fire);
      misroute_count_d = sat_inc(misroute_count_q, rx_misroute);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         alive_q          <= 1'b0;
         tx_count_q       <= '0;
         rx_count_q       <= '0;
         misroute_count_q <= '0;
      end else begin
         alive_q          <= alive_d;
         tx_count_q       <= tx_count_d;
         rx_count_q       <= rx_count_d;
         misroute_count_q <= misroute_count_d;
      end
   end

   assign o_tx_count       = tx_count_q;
   assign o_rx_count       = rx_count_q;
   assign o_misroute_count = misroute_count_q;

   pe_net_fifo #(
      .Width (DataWidth),
      .Depth (TxDepth)
   ) u_tx_fifo (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_push_valid (tx_push),
      .i_push_data  ({i_pe_dest, i_pe_payload}),
      .i_pop_ready  (i_data_ready),
      .o_head       (tx_head),
      .o_full       (tx_full),
      .o_empty      (tx_empty)
   );

   pe_net_fifo #(
      .Width (PayloadWidth),
      .Depth (RxDepth)
   ) u_rx_fifo (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_push_valid (rx_push),
      .i_push_data  (rx_payload),
      .i_pop_ready  (i_pe_rx_ready),
      .o_head       (rx_head),
      .o_full       (rx_full),
      .o_empty      (rx_empty)
   );

endmodule
